// File: rtl/cpu_pkg.sv
// Shared types and defaults for the accumulator CPU control path.
// Opcodes, sequencer states, bus/ALU select encodings, widths.
package cpu_pkg;

  localparam int OP_W_DEF = 4;
  localparam int TMO_DEF  = 15;
  localparam int CNT_W    = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_STA  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_JMP  = 4'h5,
    OP_JZ   = 4'h6,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    S_F1,
    S_F2,
    S_F3,
    S_DEC,
    S_EXR,
    S_EXA,
    S_EXW,
    S_HALT,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    BUS_PC  = 2'd0,
    BUS_IR  = 2'd1,
    BUS_MDR = 2'd2,
    BUS_ACC = 2'd3
  } bus_sel_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

endpackage

// File: rtl/cpu_wait_timer.sv
// Memory wait-state watchdog: counts stalled cycles.
// Ports: clk, rst, clr (zero count), en (count), expired.
module cpu_wait_timer
  import cpu_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High in the stalled cycle whose increment
  // would bring the count to TMO.
  assign expired = en &&
    (cnt == CNT_W'(TMO - 1));

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Fetch/decode/execute control FSM for the accumulator CPU.
// Ports: clk, rst, opcode, zero, mem_rdy in; register strobes,
// mem_rd/mem_wr, bus_sel, alu_op, halted, fault out.
module cpu_ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W = OP_W_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_rdy,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            mar_load,
  output logic            mdr_load,
  output logic            ir_load,
  output logic            acc_load,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [1:0]      bus_sel,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            fault
);

  state_t state;
  state_t nxt;

  logic wait_st;
  logic tmo_en;
  logic tmo_clr;
  logic expired;

  logic op_nop, op_lda, op_sta, op_add;
  logic op_sub, op_jmp, op_jz, op_hlt;

  assign op_nop = opcode == OP_W'(OP_NOP);
  assign op_lda = opcode == OP_W'(OP_LDA);
  assign op_sta = opcode == OP_W'(OP_STA);
  assign op_add = opcode == OP_W'(OP_ADD);
  assign op_sub = opcode == OP_W'(OP_SUB);
  assign op_jmp = opcode == OP_W'(OP_JMP);
  assign op_jz  = opcode == OP_W'(OP_JZ);
  assign op_hlt = opcode == OP_W'(OP_HALT);

  assign wait_st = (state == S_F2) ||
                   (state == S_EXR) ||
                   (state == S_EXW);
  assign tmo_en  = wait_st & ~mem_rdy;
  assign tmo_clr = ~tmo_en;

  cpu_wait_timer #(
    .TMO(TMO)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_F1;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt      = state;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    mdr_load = 1'b0;
    ir_load  = 1'b0;
    acc_load = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    bus_sel  = BUS_PC;
    alu_op   = ALU_PASS;
    halted   = 1'b0;
    fault    = 1'b0;
    unique case (state)
      S_F1: begin
        mar_load = 1'b1;
        nxt      = S_F2;
      end
      S_F2: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          mdr_load = 1'b1;
          pc_inc   = 1'b1;
          nxt      = S_F3;
        end else if (expired) begin
          nxt = S_FAULT;
        end
      end
      S_F3: begin
        ir_load = 1'b1;
        bus_sel = BUS_MDR;
        nxt     = S_DEC;
      end
      S_DEC: begin
        unique case (1'b1)
          op_nop: nxt = S_F1;
          op_lda, op_add, op_sub: begin
            mar_load = 1'b1;
            bus_sel  = BUS_IR;
            nxt      = S_EXR;
          end
          op_sta: begin
            mar_load = 1'b1;
            bus_sel  = BUS_IR;
            nxt      = S_EXW;
          end
          op_jmp: begin
            pc_load = 1'b1;
            bus_sel = BUS_IR;
            nxt     = S_F1;
          end
          op_jz: begin
            pc_load = zero;
            bus_sel = BUS_IR;
            nxt     = S_F1;
          end
          op_hlt: nxt = S_HALT;
          default: nxt = S_FAULT;
        endcase
      end
      S_EXR: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          mdr_load = 1'b1;
          nxt      = S_EXA;
        end else if (expired) begin
          nxt = S_FAULT;
        end
      end
      S_EXA: begin
        acc_load = 1'b1;
        bus_sel  = BUS_MDR;
        if (op_add) begin
          alu_op = ALU_ADD;
        end else if (op_sub) begin
          alu_op = ALU_SUB;
        end
        nxt = S_F1;
      end
      S_EXW: begin
        mem_wr  = 1'b1;
        bus_sel = BUS_ACC;
        if (mem_rdy) begin
          nxt = S_F1;
        end else if (expired) begin
          nxt = S_FAULT;
        end
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: nxt = S_FAULT;
    endcase
    // Reset is asynchronous, so strobes must
    // drop the instant it rises, not at the edge.
    if (rst) begin
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      mar_load = 1'b0;
      mdr_load = 1'b0;
      ir_load  = 1'b0;
      acc_load = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      bus_sel  = '0;
      alu_op   = '0;
      halted   = 1'b0;
      fault    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Self-checking bench for cpu_ctrl_sequencer.
// Cycle scripts come from a per-instruction reference model.
module tb_cpu_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       pc_inc, pc_load, mar_load, mdr_load;
  logic       ir_load, acc_load, mem_rd, mem_wr;
  logic [1:0] bus_sel, alu_op;
  logic       halted, fault;

  cpu_ctrl_sequencer #(
    .OP_W(4),
    .TMO (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rdy (mem_rdy),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .mar_load(mar_load),
    .mdr_load(mdr_load),
    .ir_load (ir_load),
    .acc_load(acc_load),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .bus_sel (bus_sel),
    .alu_op  (alu_op),
    .halted  (halted),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {pc_inc, pc_load, mar_load,
                mdr_load, ir_load, acc_load,
                mem_rd, mem_wr, bus_sel,
                alu_op, halted, fault};

  localparam logic [13:0] B_PCI = 14'h2000;
  localparam logic [13:0] B_PCL = 14'h1000;
  localparam logic [13:0] B_MAR = 14'h0800;
  localparam logic [13:0] B_MDR = 14'h0400;
  localparam logic [13:0] B_IR  = 14'h0200;
  localparam logic [13:0] B_ACC = 14'h0100;
  localparam logic [13:0] B_RD  = 14'h0080;
  localparam logic [13:0] B_WR  = 14'h0040;
  localparam logic [13:0] B_HLT = 14'h0002;
  localparam logic [13:0] B_FLT = 14'h0001;

  int errs = 0;
  int checks = 0;

  typedef struct packed {
    logic        rdy;
    logic [13:0] v;
  } cyc_t;

  cyc_t scr[$];

  function automatic logic [13:0] bs(int b);
    return 14'(b) << 4;
  endfunction

  function automatic logic [13:0] al(int a);
    return 14'(a) << 2;
  endfunction

  task automatic push(input logic r,
                      input logic [13:0] v);
    cyc_t c;
    c.rdy = r;
    c.v   = v;
    scr.push_back(c);
  endtask

  // Reference model: expected outputs for each cycle
  // of one instruction, with the mem_rdy to drive.
  // Non-memory cycles get random mem_rdy if noisy.
  task automatic build(input logic [3:0] op,
                       input logic z,
                       input int wf,
                       input int we,
                       input bit noisy);
    logic r;
    logic [13:0] aop;
    r = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
    scr.delete();
    push(r, B_MAR | bs(0));
    for (int k = 0; k < wf; k++) push(1'b0, B_RD);
    push(1'b1, B_RD | B_MDR | B_PCI);
    push(r, B_IR | bs(2));
    aop = (op == 4'h3) ? al(1) :
          (op == 4'h4) ? al(2) : al(0);
    case (op)
      4'h1, 4'h3, 4'h4: begin
        push(r, B_MAR | bs(1));
        for (int k = 0; k < we; k++)
          push(1'b0, B_RD);
        push(1'b1, B_RD | B_MDR);
        push(r, B_ACC | bs(2) | aop);
      end
      4'h2: begin
        push(r, B_MAR | bs(1));
        for (int k = 0; k < we; k++)
          push(1'b0, B_WR | bs(3));
        push(1'b1, B_WR | bs(3));
      end
      4'h5: push(r, B_PCL | bs(1));
      4'h6: push(r, (z ? B_PCL : 14'h0) | bs(1));
      default: push(r, 14'h0);
    endcase
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_rdy = 1'b0;
    clk_step();
    clk_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_rdy = 1'b1;
    zero = 1'b1;
    opcode = 4'(($urandom_range(0, 15)));
    #2;
    checks++;
    if (obs !== 14'h0) begin
      errs++;
      $display("FAIL reset_hold: got %h exp %h",
               obs, 14'h0);
    end
    clk_step();
    checks++;
    if (obs !== 14'h0) begin
      errs++;
      $display("FAIL reset_hold2: got %h exp %h",
               obs, 14'h0);
    end
    mem_rdy = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== (B_MAR | bs(0))) begin
      errs++;
      $display("FAIL reset_f1: got %h exp %h",
               obs, B_MAR | bs(0));
    end
    clk_step();
    checks++;
    if (obs !== B_RD) begin
      errs++;
      $display("FAIL reset_f2: got %h exp %h",
               obs, B_RD);
    end
  endtask

  task automatic test_lda();
    do_reset();
    opcode = 4'h1;
    zero = 1'b0;
    build(4'h1, 1'b0, 0, 0, 1'b0);
    push(1'b1, B_MAR | bs(0));
    for (int i = 0; i < scr.size(); i++) begin
      mem_rdy = scr[i].rdy;
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL lda cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
  endtask

  task automatic test_sta_wait();
    do_reset();
    opcode = 4'h2;
    build(4'h2, 1'b0, 0, 3, 1'b1);
    push(1'b0, B_MAR | bs(0));
    for (int i = 0; i < scr.size(); i++) begin
      mem_rdy = scr[i].rdy;
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL sta cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
  endtask

  task automatic test_jz();
    for (int zz = 1; zz >= 0; zz--) begin
      do_reset();
      opcode = 4'h6;
      zero = 1'(zz);
      build(4'h6, 1'(zz), 0, 0, 1'b1);
      push(1'b0, B_MAR | bs(0));
      for (int i = 0; i < scr.size(); i++) begin
        mem_rdy = scr[i].rdy;
        #2;
        checks++;
        if (obs !== scr[i].v) begin
          errs++;
          $display("FAIL jz%0d cyc %0d: got %h exp %h",
                   zz, i, obs, scr[i].v);
        end
        clk_step();
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 4'h9;
    build(4'h9, 1'b0, 1, 0, 1'b1);
    for (int k = 0; k < 20; k++)
      push(1'($urandom_range(0, 1)), B_FLT);
    for (int i = 0; i < scr.size(); i++) begin
      mem_rdy = scr[i].rdy;
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL illegal cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      errs++;
      $display("FAIL illegal_rst: got %h exp %h",
               obs, 14'h0);
    end
    clk_step();
    rst = 1'b0;
    mem_rdy = 1'b0;
    #1;
    checks++;
    if (obs !== (B_MAR | bs(0))) begin
      errs++;
      $display("FAIL illegal_f1: got %h exp %h",
               obs, B_MAR | bs(0));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 4'h0;
    scr.delete();
    push(1'b0, B_MAR | bs(0));
    for (int k = 0; k < 15; k++) push(1'b0, B_RD);
    for (int k = 0; k < 3; k++)
      push(1'($urandom_range(0, 1)), B_FLT);
    for (int i = 0; i < scr.size(); i++) begin
      mem_rdy = scr[i].rdy;
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL tmo cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
    do_reset();
    build(4'h0, 1'b0, 14, 0, 1'b1);
    push(1'b0, B_MAR | bs(0));
    for (int i = 0; i < scr.size(); i++) begin
      mem_rdy = scr[i].rdy;
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL tmo_rdy cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 4'hF;
    build(4'hF, 1'b0, 2, 0, 1'b1);
    for (int k = 0; k < 10; k++)
      push(1'($urandom_range(0, 1)), B_HLT);
    for (int i = 0; i < scr.size(); i++) begin
      mem_rdy = scr[i].rdy;
      zero = 1'($urandom_range(0, 1));
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL halt cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    opcode = 4'h1;
    build(4'h1, 1'b0, 0, 5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      mem_rdy = scr[i].rdy;
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL rstmid cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
    mem_rdy = 1'b0;
    #1;
    checks++;
    if (obs !== B_RD) begin
      errs++;
      $display("FAIL rstmid_exr: got %h exp %h",
               obs, B_RD);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      errs++;
      $display("FAIL rstmid_drop: got %h exp %h",
               obs, 14'h0);
    end
    clk_step();
    rst = 1'b0;
    // A retained wait count would fault here.
    opcode = 4'h0;
    build(4'h0, 1'b0, 14, 0, 1'b1);
    push(1'b0, B_MAR | bs(0));
    for (int i = 0; i < scr.size(); i++) begin
      mem_rdy = scr[i].rdy;
      #2;
      checks++;
      if (obs !== scr[i].v) begin
        errs++;
        $display("FAIL rstmid_f cyc %0d: got %h exp %h",
                 i, obs, scr[i].v);
      end
      clk_step();
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [7];
    logic [3:0] op;
    logic       z;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      z  = 1'($urandom_range(0, 1));
      opcode = op;
      zero = z;
      build(op, z, $urandom_range(0, 5),
            $urandom_range(0, 5), 1'b1);
      for (int i = 0; i < scr.size(); i++) begin
        mem_rdy = scr[i].rdy;
        #2;
        checks++;
        if (obs !== scr[i].v) begin
          errs++;
          $display("FAIL rnd op%h n%0d c%0d: got %h exp %h",
                   op, n, i, obs, scr[i].v);
        end
        clk_step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sta_wait();
    test_jz();
    test_illegal();
    test_timeout();
    test_halt();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
